// File: rtl/hack_video_pkg.sv
// rtl/hack_video_pkg.sv - timing, window and colour constants shared by the video blocks
package hack_video_pkg;

    // 640x480 timing, counts in pixels (h) and lines (v); sync ranges are inclusive
    localparam logic [9:0] H_ACTIVE     = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd751;
    localparam logic [9:0] H_TOTAL      = 10'd800;
    localparam logic [9:0] V_ACTIVE     = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd491;
    localparam logic [9:0] V_TOTAL      = 10'd525;

    // 512x256 monochrome screen centred in the active area
    localparam logic [9:0] WIN_X0 = 10'd64;
    localparam logic [9:0] WIN_Y0 = 10'd112;
    localparam logic [9:0] WIN_W  = 10'd512;
    localparam logic [9:0] WIN_H  = 10'd256;

    localparam logic [23:0] RGB_BLACK = 24'h000000;
    localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;

    typedef struct packed {
        logic hblank;
        logic vblank;
        logic hsync;
        logic vsync;
    } sync_t;

endpackage

// File: rtl/hack_video_timing.sv
// rtl/hack_video_timing.sv - pixel divider, h/v counters and sync/blank decode
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   ce_pix_o       pixel enable, high one clk in every CE_DIV
//   h_cnt_o        horizontal pixel counter 0..799
//   v_cnt_o        vertical line counter 0..524
//   sync_o         unregistered blank/sync decode of the current counters
module hack_video_timing
    import hack_video_pkg::*;
#(
    parameter int CE_DIV = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       ce_pix_o,
    output logic [9:0] h_cnt_o,
    output logic [9:0] v_cnt_o,
    output sync_t      sync_o
);

    localparam logic [3:0] DIV_LAST = 4'(CE_DIV - 1);

    logic [3:0] div_q, div_d;
    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       ce;

    always_comb begin
        ce    = (div_q == DIV_LAST);
        div_d = ce ? 4'd0 : div_q + 4'd1;
        h_d   = h_q;
        v_d   = v_q;
        if (ce) begin
            if (h_q == H_TOTAL - 10'd1) begin
                h_d = 10'd0;
                v_d = (v_q == V_TOTAL - 10'd1) ? 10'd0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= 4'd0;
            h_q   <= 10'd0;
            v_q   <= 10'd0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    always_comb begin
        sync_o.hblank = (h_q >= H_ACTIVE);
        sync_o.vblank = (v_q >= V_ACTIVE);
        sync_o.hsync  = (h_q >= H_SYNC_START) && (h_q <= H_SYNC_END);
        sync_o.vsync  = (v_q >= V_SYNC_START) && (v_q <= V_SYNC_END);
    end

    assign ce_pix_o = ce;
    assign h_cnt_o  = h_q;
    assign v_cnt_o  = v_q;

endmodule

// File: rtl/hack_video.sv
// rtl/hack_video.sv - Hack 512x256 monochrome screen to 640x480 video with word prefetch
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   ram_addr, ram_rd          screen RAM word address (y*32+k) and one-clk read strobe
//   ram_data                  screen RAM data, valid 1 clk after ram_rd
//   ce_pix                    pixel enable
//   HBlank/VBlank/HSync/VSync timing outputs, sync active-high
//   vga_r/vga_g/vga_b         pixel colour
module hack_video
    import hack_video_pkg::*;
#(
    parameter int          CE_DIV     = 4,
    parameter logic [23:0] BORDER_RGB = 24'h202020
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [12:0] ram_addr,
    output logic        ram_rd,
    input  logic [15:0] ram_data,
    output logic        ce_pix,
    output logic        HBlank,
    output logic        VBlank,
    output logic        HSync,
    output logic        VSync,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b
);

    logic       ce;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    sync_t      sync_now;

    hack_video_timing #(
        .CE_DIV(CE_DIV)
    ) u_timing (
        .clk     (clk),
        .reset_n (reset_n),
        .ce_pix_o(ce),
        .h_cnt_o (h_cnt),
        .v_cnt_o (v_cnt),
        .sync_o  (sync_now)
    );

    logic [12:0] ram_addr_q, ram_addr_d;
    logic        ram_rd_q;
    logic        cap_pend_q;
    logic [15:0] fetch_q;
    logic [15:0] shift_q;
    sync_t       sync_q;
    logic [23:0] rgb_q, rgb_d;

    logic        in_win_h, in_win_v, in_win;
    logic        fetch_go;
    logic        word_start;
    logic [7:0]  y;
    logic [4:0]  k;
    logic [15:0] fetch_word;
    logic [15:0] word_now;
    logic        pix;

    always_comb begin
        in_win_v = (v_cnt >= WIN_Y0) && (v_cnt < WIN_Y0 + WIN_H);
        in_win_h = (h_cnt >= WIN_X0) && (h_cnt < WIN_X0 + WIN_W);
        in_win   = in_win_h && in_win_v;
        y        = 8'(v_cnt - WIN_Y0);
        // WIN_X0 is a multiple of 16, so x[3:0] equals h[3:0] and the pixel
        // before each word start is the one with h[3:0] == 15.
        word_start = (h_cnt[3:0] == 4'd0);
        fetch_go   = ce && in_win_v && (h_cnt[3:0] == 4'hF)
                     && (h_cnt >= WIN_X0 - 10'd1) && (h_cnt < WIN_X0 + WIN_W - 10'd1);
        k          = 5'((h_cnt + 10'd1 - WIN_X0) >> 4);
        ram_addr_d = fetch_go ? {y, k} : ram_addr_q;

        // With CE_DIV=2 the capture edge and the word-start pixel edge coincide,
        // so the word is taken straight from the RAM bus in that cycle.
        fetch_word = cap_pend_q ? ram_data : fetch_q;
        word_now   = word_start ? fetch_word : shift_q;
        pix        = word_now[h_cnt[3:0]];

        rgb_d = RGB_BLACK;
        if (!sync_now.hblank && !sync_now.vblank) begin
            if (in_win) begin
                rgb_d = pix ? RGB_BLACK : RGB_WHITE;
            end else begin
                rgb_d = BORDER_RGB;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr_q <= 13'd0;
            ram_rd_q   <= 1'b0;
            cap_pend_q <= 1'b0;
            fetch_q    <= 16'd0;
            shift_q    <= 16'd0;
            sync_q     <= '0;
            rgb_q      <= 24'd0;
        end else begin
            ram_addr_q <= ram_addr_d;
            ram_rd_q   <= fetch_go;
            cap_pend_q <= ram_rd_q;
            if (cap_pend_q) begin
                fetch_q <= ram_data;
            end
            if (ce && in_win && word_start) begin
                shift_q <= fetch_word;
            end
            // Timing and colour share one register stage so they stay aligned.
            if (ce) begin
                sync_q <= sync_now;
                rgb_q  <= rgb_d;
            end
        end
    end

    assign ram_addr = ram_addr_q;
    assign ram_rd   = ram_rd_q;
    assign ce_pix   = ce;
    assign HBlank   = sync_q.hblank;
    assign VBlank   = sync_q.vblank;
    assign HSync    = sync_q.hsync;
    assign VSync    = sync_q.vsync;
    assign vga_r    = rgb_q[23:16];
    assign vga_g    = rgb_q[15:8];
    assign vga_b    = rgb_q[7:0];

endmodule

// File: tb/tb_hack_video.sv
// tb/tb_hack_video.sv - scoreboard bench for hack_video
module tb_hack_video;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [12:0] ram_addr;
    logic        ram_rd;
    logic [15:0] ram_data = 16'd0;
    logic        ce_pix;
    logic        HBlank, VBlank, HSync, VSync;
    logic [7:0]  vga_r, vga_g, vga_b;

    int checks = 0;
    int errors = 0;

    hack_video dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ram_addr(ram_addr),
        .ram_rd  (ram_rd),
        .ram_data(ram_data),
        .ce_pix  (ce_pix),
        .HBlank  (HBlank),
        .VBlank  (VBlank),
        .HSync   (HSync),
        .VSync   (VSync),
        .vga_r   (vga_r),
        .vga_g   (vga_g),
        .vga_b   (vga_b)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ram_word(input int a);
        return (a == 0) ? 16'h0001 : 16'(a);
    endfunction

    // Model RAM: data for a strobe appears one clk later, garbage otherwise.
    always @(posedge clk) begin
        ram_data <= ram_rd ? ram_word(int'(ram_addr)) : 16'($urandom);
    end

    function automatic logic [27:0] exp_vec(input int h, input int v);
        logic [23:0] rgb;
        logic [15:0] w;
        int x, y;
        if (h >= 640 || v >= 480) begin
            rgb = 24'h000000;
        end else if (h >= 64 && h < 576 && v >= 112 && v < 368) begin
            x = h - 64;
            y = v - 112;
            w = ram_word(y * 32 + x / 16);
            rgb = w[x % 16] ? 24'h000000 : 24'hFFFFFF;
        end else begin
            rgb = 24'h202020;
        end
        return {h >= 640, v >= 480, (h >= 656 && h <= 751), (v >= 490 && v <= 491), rgb};
    endfunction

    typedef struct {
        int          h;
        int          v;
        logic [27:0] vec;
    } sb_t;

    sb_t sbq[$];
    int  rdq[$];
    int  m_h = 0, m_v = 0;
    int  line_bad = 0, first_h = 0;
    logic [27:0] first_act, first_exp, act;
    int  strobes = 0, last_addr = -1;

    always @(negedge clk) begin
        if (!reset_n) begin
            sbq.delete();
            rdq.delete();
            m_h = 0;
            m_v = 0;
            line_bad = 0;
            strobes = 0;
            last_addr = -1;
        end else begin
            if (ram_rd) begin
                int exp_a;
                exp_a = (rdq.size() > 0) ? rdq.pop_front() : -1;
                checks++;
                assert (int'(ram_addr) == exp_a) else begin
                    errors++;
                    $error("FAIL ram_addr: got %0d expected %0d", ram_addr, exp_a);
                end
                strobes++;
                last_addr = int'(ram_addr);
            end
            if (ce_pix) begin
                if (sbq.size() > 0) begin
                    sb_t e;
                    e = sbq.pop_front();
                    act = {HBlank, VBlank, HSync, VSync, vga_r, vga_g, vga_b};
                    if (act !== e.vec) begin
                        if (line_bad == 0) begin
                            first_h = e.h;
                            first_act = act;
                            first_exp = e.vec;
                        end
                        line_bad++;
                    end
                    if (e.v == 10 && e.h == 10) begin
                        checks++;
                        assert ({HBlank, vga_r, vga_g, vga_b} === {1'b0, 24'h202020}) else begin
                            errors++;
                            $error("FAIL border: got %h expected %h", {HBlank, vga_r, vga_g, vga_b}, {1'b0, 24'h202020});
                        end
                    end
                    if (e.v == 10 && e.h == 700) begin
                        checks++;
                        assert ({HBlank, vga_r, vga_g, vga_b} === {1'b1, 24'h000000}) else begin
                            errors++;
                            $error("FAIL hblank: got %h expected %h", {HBlank, vga_r, vga_g, vga_b}, {1'b1, 24'h000000});
                        end
                    end
                    if (e.v == 112 && e.h == 64) begin
                        checks++;
                        assert ({vga_r, vga_g, vga_b} === 24'h000000) else begin
                            errors++;
                            $error("FAIL pixel x0: got %h expected %h", {vga_r, vga_g, vga_b}, 24'h000000);
                        end
                    end
                    if (e.v == 112 && (e.h == 65 || e.h == 79)) begin
                        checks++;
                        assert ({vga_r, vga_g, vga_b} === 24'hFFFFFF) else begin
                            errors++;
                            $error("FAIL pixel h=%0d: got %h expected %h", e.h, {vga_r, vga_g, vga_b}, 24'hFFFFFF);
                        end
                    end
                    if (e.h == 799) begin
                        checks++;
                        assert (line_bad == 0) else begin
                            errors++;
                            $error("FAIL line v=%0d: %0d bad pixels (expected 0), first h=%0d got %h expected %h",
                                   e.v, line_bad, first_h, first_act, first_exp);
                        end
                        line_bad = 0;
                    end
                end
                if (m_h == 0 && m_v == 0) begin
                    strobes = 0;
                end
                if (m_h == 0 && m_v == 368) begin
                    checks++;
                    assert (strobes == 8192) else begin
                        errors++;
                        $error("FAIL strobe count: got %0d expected 8192", strobes);
                    end
                    checks++;
                    assert (last_addr == 8191) else begin
                        errors++;
                        $error("FAIL last addr: got %0d expected 8191", last_addr);
                    end
                end
                if (m_v >= 112 && m_v < 368 && (m_h % 16) == 15 && m_h >= 63 && m_h <= 559) begin
                    checks++;
                    assert (rdq.size() == 0) else begin
                        errors++;
                        $error("FAIL unserved reads: got %0d expected 0", rdq.size());
                    end
                    rdq.push_back((m_v - 112) * 32 + (m_h + 1 - 64) / 16);
                end
                sbq.push_back('{h: m_h, v: m_v, vec: exp_vec(m_h, m_v)});
                if (m_h == 799) begin
                    m_h = 0;
                    m_v = (m_v == 524) ? 0 : m_v + 1;
                end else begin
                    m_h = m_h + 1;
                end
            end
        end
    end

    logic [42:0] all_out;
    assign all_out = {ce_pix, ram_rd, ram_addr, HBlank, VBlank, HSync, VSync, vga_r, vga_g, vga_b};

    initial begin
        int  n, spurious, ce_total, vs_ce, hs_w;
        bit  found, hs_done, prev_vs;

        reset_n = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        assert (all_out === 43'd0) else begin
            errors++;
            $error("FAIL reset outputs: got %h expected 0", all_out);
        end

        @(posedge clk);
        #1 reset_n = 1'b1;
        n = 0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (ce_pix) begin
                found = 1;
                break;
            end
        end
        checks++;
        assert (found && n == 4) else begin
            errors++;
            $error("FAIL first ce_pix: got %0d clk expected 4", n);
        end
        for (int p = 0; p < 3; p++) begin
            n = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                n++;
                if (ce_pix) break;
            end
            checks++;
            assert (n == 4) else begin
                errors++;
                $error("FAIL ce_pix period: got %0d expected 4", n);
            end
        end

        // Abort a fetch on line 200 while the read is outstanding.
        found = 0;
        for (int i = 0; i < 800000; i++) begin
            @(negedge clk);
            #2;
            if (m_v == 200 && m_h >= 300 && ram_rd) begin
                found = 1;
                break;
            end
        end
        checks++;
        assert (found) else begin
            errors++;
            $error("FAIL reach v200 fetch: got %0d expected 1", found);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        assert (all_out === 43'd0) else begin
            errors++;
            $error("FAIL mid-fetch reset outputs: got %h expected 0", all_out);
        end
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b1;

        spurious = 0;
        found = 0;
        for (int i = 0; i < 400000; i++) begin
            @(negedge clk);
            #2;
            if (m_v == 112) begin
                found = 1;
                break;
            end
            if (ram_rd) spurious++;
        end
        checks++;
        assert (found && spurious == 0) else begin
            errors++;
            $error("FAIL reads before window: got %0d expected 0 (reached=%0d)", spurious, found);
        end

        found = 0;
        prev_vs = 0;
        for (int i = 0; i < 1400000; i++) begin
            @(negedge clk);
            if (VSync && !prev_vs) begin
                found = 1;
                break;
            end
            prev_vs = VSync;
        end
        checks++;
        assert (found) else begin
            errors++;
            $error("FAIL first VSync rise: got %0d expected 1", found);
        end

        ce_total = 0;
        vs_ce = 0;
        hs_w = 0;
        hs_done = 0;
        prev_vs = 1;
        found = 0;
        for (int i = 0; i < 1700000; i++) begin
            @(negedge clk);
            if (VSync && !prev_vs) begin
                found = 1;
                break;
            end
            prev_vs = VSync;
            if (ce_pix) begin
                ce_total++;
                if (VSync) vs_ce++;
                if (HSync && !hs_done) hs_w++;
            end
            if (!HSync && hs_w > 0) hs_done = 1;
        end
        checks++;
        assert (found && ce_total == 420000) else begin
            errors++;
            $error("FAIL frame period: got %0d expected 420000", ce_total);
        end
        checks++;
        assert (hs_w == 96) else begin
            errors++;
            $error("FAIL HSync width: got %0d expected 96", hs_w);
        end
        checks++;
        assert (vs_ce == 1600) else begin
            errors++;
            $error("FAIL VSync width: got %0d expected 1600", vs_ce);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
